mux_sel_rr_arbiter: RTL and testbench

- Round-robin arbiter that sits directly upstream of the team's 4:1 MUX and drives its 2-bit Sel.
- Four requesters compete for the shared MUX input lane; the winner's index is registered onto Sel and held for the whole grant.
- Fairness comes from a rotating priority pointer. An optional hold timeout forcibly releases a requester that never finishes.

---
 rtl/mux_sel_rr_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_mux_sel_rr_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mux_sel_rr_arbiter.sv
// mux_sel_rr_arbiter
//
// This block is a round-robin arbiter that sits directly in front of the shared 4:1 MUX.
// It drives the MUX select lines.
//
// Grant cycle:
//   - The winning requester's index is registered onto Sel.
//   - Sel is held there for the whole grant.
//   - The grant ends on Done from the owner, or when the owner drops Req.
//   - Every grant is followed by one bubble cycle.
//   - Because of the bubble, the MUX is never switched back-to-back.
//
// Fairness:
//   - A rotating priority pointer moves to the slot after the last owner.
//
// Optional feature (macro MUX_SEL_ARB_TIMEOUT_EN):
//   - A hold counter force-releases any grant that lasts HOLD_MAX cycles.
//   - Timeout pulses for one cycle during the bubble that follows a forced release.
//   - Without the macro there is no counter, and Timeout is tied low.
//
// Parameters:
//   HOLD_MAX : maximum grant length in cycles (timeout build only), >= 1
//   CNT_W    : hold counter width, derived from HOLD_MAX
//
// Ports:
//   clk     : rising-edge clock
//   rst     : asynchronous active-high reset
//   Req     : per-requester level request
//   Done    : per-requester release pulse; only the owner's bit matters
//   Sel     : registered MUX select, index of the current or last grant
//   Gnt     : registered one-hot grant, zero when idle
//   Valid   : high while a grant is active
//   Timeout : one-cycle pulse after a forced release

module mux_sel_rr_arbiter #(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = $clog2(HOLD_MAX + 1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] Req,
  input  logic [3:0] Done,
  output logic [1:0] Sel,
  output logic [3:0] Gnt,
  output logic       Valid,
  output logic       Timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] gnt_q, gnt_d;
  logic       valid_q, valid_d;
  logic       timeout_q, timeout_d;

  logic [1:0] pickIdx;
  logic [1:0] candidate;
  logic       normalRelease;
  logic       holdExpired;
  logic       startGrant;
  logic       releaseNow;

  if (HOLD_MAX < 1 || CNT_W < 1) begin : gHoldMaxCheck
    $error("mux_sel_rr_arbiter: HOLD_MAX must be at least 1");
  end

  // Scan from the highest offset down to offset 0.
  // The last match is therefore the first requester at or after the pointer.
  always_comb begin
    pickIdx   = ptr_q;
    candidate = ptr_q;
    for (int i = 3; i >= 0; i--) begin
      candidate = ptr_q + 2'(i);
      if (Req[candidate]) begin
        pickIdx = candidate;
      end
    end
  end

  // Done and a Req drop on the same edge are a single release.
  // Either one on its own also releases.
  assign normalRelease = Done[sel_q] | ~Req[sel_q];
  assign startGrant    = (state_q == IDLE) && (|Req);
  assign releaseNow    = (state_q == GRANT) && (normalRelease || holdExpired);

`ifdef MUX_SEL_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] holdCnt_q, holdCnt_d;

  // The counter is 0 on the granting edge.
  // It therefore reaches HOLD_MAX-1 on the edge that ends cycle HOLD_MAX of the grant.
  assign holdExpired = (state_q == GRANT) && (holdCnt_q == CNT_W'(HOLD_MAX - 1));

  always_comb begin
    holdCnt_d = holdCnt_q;
    if (startGrant) begin
      holdCnt_d = '0;
    end else if (state_q == GRANT && !releaseNow) begin
      if (holdCnt_q != CNT_W'(HOLD_MAX)) begin
        holdCnt_d = holdCnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      holdCnt_q <= '0;
    end else begin
      holdCnt_q <= holdCnt_d;
    end
  end

  assign Timeout = timeout_q;
`else
  assign holdExpired = 1'b0;
  assign Timeout     = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    sel_d     = sel_q;
    gnt_d     = gnt_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (startGrant) begin
          sel_d   = pickIdx;
          gnt_d   = 4'b0001 << pickIdx;
          valid_d = 1'b1;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (releaseNow) begin
          gnt_d     = 4'b0000;
          valid_d   = 1'b0;
          ptr_d     = sel_q + 2'd1;
          state_d   = RELEASE;
          // A forced release that coincides with Done or a Req drop counts as a normal release.
          timeout_d = holdExpired & ~normalRelease;
        end
      end
      RELEASE: begin
        gnt_d   = 4'b0000;
        valid_d = 1'b0;
        state_d = IDLE;
      end
      default: begin
        gnt_d   = 4'b0000;
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= 2'd0;
      sel_q     <= 2'd0;
      gnt_q     <= 4'b0000;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      sel_q     <= sel_d;
      gnt_q     <= gnt_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign Sel   = sel_q;
  assign Gnt   = gnt_q;
  assign Valid = valid_q;

endmodule

// File: tb/tb_mux_sel_rr_arbiter.sv
// tb_mux_sel_rr_arbiter
//
// This bench has two phases:
//   - A directed phase covering reset, single grants, rotation, wrap/skip, hold limits and simultaneous release.
//   - A randomized phase.
//
// Every cycle is compared against a behavioural model.
// The model tracks:
//   - the owner,
//   - the rotating pointer,
//   - the cycles held,
//   - the bubble.

module tb_mux_sel_rr_arbiter;

  localparam int HoldMax = 8;
`ifdef MUX_SEL_ARB_TIMEOUT_EN
  localparam bit TimeoutOn = 1'b1;
`else
  localparam bit TimeoutOn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] Req;
  logic [3:0] Done;
  logic [1:0] Sel;
  logic [3:0] Gnt;
  logic       Valid;
  logic       Timeout;

  int vectors     = 0;
  int miscompares = 0;

  int mPtr;
  int mOwner;
  int mSel;
  int mHeld;
  bit mBubble;
  bit mTimeout;

  mux_sel_rr_arbiter #(.HOLD_MAX(HoldMax)) dut (
    .clk     (clk),
    .rst     (rst),
    .Req     (Req),
    .Done    (Done),
    .Sel     (Sel),
    .Gnt     (Gnt),
    .Valid   (Valid),
    .Timeout (Timeout)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h, expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mPtr     = 0;
    mOwner   = -1;
    mSel     = 0;
    mHeld    = 0;
    mBubble  = 1'b0;
    mTimeout = 1'b0;
  endtask

  // One clock edge of the arbiter rules, evaluated on the inputs present at that edge.
  task automatic modelStep();
    bit relNormal;
    bit relForced;
    mTimeout = 1'b0;
    if (mOwner >= 0) begin
      relNormal = Done[mOwner] || !Req[mOwner];
      relForced = TimeoutOn && (mHeld == HoldMax);
      if (relNormal || relForced) begin
        mPtr     = (mOwner + 1) % 4;
        mOwner   = -1;
        mBubble  = 1'b1;
        mTimeout = relForced && !relNormal;
      end else begin
        mHeld++;
      end
    end else if (mBubble) begin
      mBubble = 1'b0;
    end else if (Req != 4'b0000) begin
      for (int k = 0; k < 4; k++) begin
        int c;
        c = (mPtr + k) % 4;
        if (Req[c]) begin
          mOwner = c;
          mSel   = c;
          mHeld  = 1;
          break;
        end
      end
    end
  endtask

  task automatic compareAll(input string phase);
    logic [3:0] expGnt;
    expGnt = (mOwner >= 0) ? 4'(1 << mOwner) : 4'b0000;
    checkOutput({phase, ":Sel"},     32'(Sel),     32'(mSel));
    checkOutput({phase, ":Gnt"},     32'(Gnt),     32'(expGnt));
    checkOutput({phase, ":Valid"},   32'(Valid),   32'(mOwner >= 0));
    checkOutput({phase, ":Timeout"}, 32'(Timeout), 32'(mTimeout));
  endtask

  // Called at a falling edge.
  // Drives the inputs, lets one rising edge pass, then compares at the next falling edge.
  task automatic applyStimulus(input logic [3:0] req, input logic [3:0] done, input string phase);
    Req  = req;
    Done = done;
    @(posedge clk);
    modelStep();
    @(negedge clk);
    compareAll(phase);
  endtask

  initial begin
    logic [3:0] r;
    logic [3:0] d;

    rst  = 1'b1;
    Req  = 4'b0000;
    Done = 4'b0000;
    modelReset();
    repeat (2) @(negedge clk);
    compareAll("reset");
    rst = 1'b0;

    applyStimulus(4'b0000, 4'b0000, "idle");
    applyStimulus(4'b0100, 4'b0000, "single");
    applyStimulus(4'b0100, 4'b0100, "singleDone");
    applyStimulus(4'b0000, 4'b0000, "bubble");
    applyStimulus(4'b0000, 4'b0000, "idleAgain");

    for (int n = 0; n < 30; n++) begin
      d = (mOwner >= 0 && mHeld == 2) ? 4'(1 << mOwner) : 4'b0000;
      applyStimulus(4'b1111, d, "rotate");
    end

    applyStimulus(4'b0000, 4'b0000, "drain");
    applyStimulus(4'b0000, 4'b0000, "drain");
    applyStimulus(4'b0100, 4'b0000, "wrapGrant2");
    applyStimulus(4'b0100, 4'b0100, "wrapDone2");
    applyStimulus(4'b0011, 4'b0000, "wrapBubble");
    applyStimulus(4'b0011, 4'b0000, "wrapGrant0");
    applyStimulus(4'b0011, 4'b1000, "foreignDone");
    applyStimulus(4'b0011, 4'b0001, "wrapDone0");
    applyStimulus(4'b0011, 4'b0000, "skipBubble");
    applyStimulus(4'b0011, 4'b0000, "skipGrant1");
    applyStimulus(4'b0000, 4'b0000, "dropRelease");
    applyStimulus(4'b0000, 4'b0000, "drain");

    for (int n = 0; n < 34; n++) begin
      applyStimulus(4'b0001, 4'b0000, "hold");
    end
    applyStimulus(4'b0000, 4'b0000, "holdDrop");
    applyStimulus(4'b0000, 4'b0000, "drain");
    applyStimulus(4'b0000, 4'b0000, "drain");

    applyStimulus(4'b0010, 4'b0000, "simulGrant");
    applyStimulus(4'b0000, 4'b0010, "simulRelease");
    applyStimulus(4'b0000, 4'b0000, "simulBubble");
    applyStimulus(4'b1110, 4'b0000, "simulPtr");

    applyStimulus(4'b1111, 4'b0000, "preReset");
    applyStimulus(4'b1111, 4'b0000, "preReset");
    #2;
    rst = 1'b1;
    modelReset();
    #1;
    compareAll("asyncReset");
    @(negedge clk);
    compareAll("heldReset");
    rst = 1'b0;
    applyStimulus(4'b1111, 4'b0000, "postReset");

    r = 4'b0000;
    for (int n = 0; n < 500; n++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(5) == 0) r[b] = ~r[b];
      end
      case ($urandom_range(5))
        0:       d = 4'(1 << mSel);
        1:       d = 4'($urandom);
        default: d = 4'b0000;
      endcase
      applyStimulus(r, d, "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
